// File: rtl/binder_hf_pkg.sv
// Shared definitions for the binder_hf hypervector binding unit:
// FSM state encoding and the chunk-count helper.
package binder_hf_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/binder_hf_chunk_xor.sv
// Produces the XOR of one CHUNK_WIDTH-wide slice of the latched operands,
// positioned in place, together with a mask marking which bits that slice covers.
module hv_chunk_xor
    import binder_hf_pkg::*;
#(
    parameter int DIMENSIONS  = 10000,
    parameter int CHUNK_WIDTH = 1000,
    localparam int NUM_CHUNKS = ceil_div(DIMENSIONS, CHUNK_WIDTH),
    localparam int IDX_W      = $clog2(NUM_CHUNKS + 1)
) (
    input  logic [DIMENSIONS-1:0] a,
    input  logic [DIMENSIONS-1:0] b,
    input  logic [IDX_W-1:0]      idx,
    output logic [DIMENSIONS-1:0] slice,
    output logic [DIMENSIONS-1:0] mask
);

    // The last chunk is narrowed so the mask never reaches past DIMENSIONS.
    for (genvar c = 0; c < NUM_CHUNKS; c++) begin : g_chunk
        localparam int LO = c * CHUNK_WIDTH;
        localparam int W  = (c == NUM_CHUNKS - 1) ? (DIMENSIONS - LO) : CHUNK_WIDTH;
        assign mask[LO +: W] = {W{idx == IDX_W'(c)}};
    end

    assign slice = (a ^ b) & mask;

endmodule

// File: rtl/binder_hf.sv
// Binds two hypervectors by XOR, folded over NUM_CHUNKS cycles, and flags
// completion with a one-cycle registered pulse on out.
module binder_hf
    import binder_hf_pkg::*;
#(
    parameter int DIMENSIONS  = 10000,
    parameter int CHUNK_WIDTH = 1000,
    localparam int NUM_CHUNKS = ceil_div(DIMENSIONS, CHUNK_WIDTH),
    localparam int IDX_W      = $clog2(NUM_CHUNKS + 1)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic [DIMENSIONS-1:0] hv1,
    input  logic [DIMENSIONS-1:0] hv2,
    output logic                  out,
    output logic [DIMENSIONS-1:0] hv_out
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    state_t                  state;
    state_t                  next_state;
    logic [IDX_W-1:0]        idx;
    logic [DIMENSIONS-1:0]   op_a;
    logic [DIMENSIONS-1:0]   op_b;
    logic [DIMENSIONS-1:0]   slice;
    logic [DIMENSIONS-1:0]   mask;
    logic                    last_chunk;

    hv_chunk_xor #(
        .DIMENSIONS  (DIMENSIONS),
        .CHUNK_WIDTH (CHUNK_WIDTH)
    ) u_chunk_xor (
        .a     (op_a),
        .b     (op_b),
        .idx   (idx),
        .slice (slice),
        .mask  (mask)
    );

    assign last_chunk = (idx == LAST_IDX);

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (en) next_state = BUSY;
            BUSY: if (last_chunk) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // nrst is active-high despite its name; it clears everything asynchronously.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state  <= IDLE;
            idx    <= '0;
            out    <= 1'b0;
            hv_out <= '0;
            op_a   <= '0;
            op_b   <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    out <= 1'b0;
                    if (en) begin
                        op_a <= hv1;
                        op_b <= hv2;
                        idx  <= '0;
                    end
                end
                BUSY: begin
                    hv_out <= (hv_out & ~mask) | slice;
                    idx    <= idx + IDX_W'(1);
                    out    <= last_chunk;
                end
                default: out <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_binder_hf.sv
// Randomised self-checking bench for binder_hf, exercising a 10-chunk and a
// 4-chunk instance side by side against a chunk-level behavioural model.
module tb_binder_hf;

    localparam int D = 10000;

    logic         clk = 1'b0;
    logic         nrst = 1'b1;
    logic         en = 1'b0;
    logic [D-1:0] hv1 = '0;
    logic [D-1:0] hv2 = '0;
    logic         out_a;
    logic         out_b;
    logic [D-1:0] hv_out_a;
    logic [D-1:0] hv_out_b;

    int n_vectors = 0;
    int n_miscompares = 0;

    // Reference model state, one entry per instance.
    int           cw[2]  = '{1000, 3000};
    int           nch[2] = '{10, 4};
    bit           m_busy[2];
    int           m_done[2];
    logic [D-1:0] m_old[2];
    logic [D-1:0] m_new[2];
    logic [D-1:0] exp_hv[2];
    logic         exp_out[2];

    binder_hf #(.DIMENSIONS(D), .CHUNK_WIDTH(1000)) dut_a (
        .clk(clk), .nrst(nrst), .en(en), .hv1(hv1), .hv2(hv2),
        .out(out_a), .hv_out(hv_out_a)
    );

    binder_hf #(.DIMENSIONS(D), .CHUNK_WIDTH(3000)) dut_b (
        .clk(clk), .nrst(nrst), .en(en), .hv1(hv1), .hv2(hv2),
        .out(out_b), .hv_out(hv_out_b)
    );

    always #5 clk = ~clk;

    function automatic logic [D-1:0] rand_hv();
        logic [D-1:0] r;
        for (int i = 0; i < D; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // Bits whose chunk has already been written take the new value.
    function automatic logic [D-1:0] mix(input logic [D-1:0] old_v, input logic [D-1:0] new_v,
                                         input int done, input int width);
        logic [D-1:0] r;
        for (int i = 0; i < D; i++) r[i] = ((i / width) < done) ? new_v[i] : old_v[i];
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [D-1:0] observed, input logic [D-1:0] expected);
        int first;
        int base;
        n_vectors++;
        if (observed !== expected) begin
            n_miscompares++;
            first = 0;
            for (int i = D - 1; i >= 0; i--) if (observed[i] !== expected[i]) first = i;
            base = (first / 64) * 64;
            $display("[TB] FAIL %s: got %h, expected %h (64-bit window from bit %0d) at %0t",
                     tag, 64'(observed >> base), 64'(expected >> base), base, $time);
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (nrst) begin
                m_busy[d]  = 1'b0;
                m_done[d]  = 0;
                exp_out[d] = 1'b0;
                exp_hv[d]  = '0;
            end else begin
                exp_out[d] = 1'b0;
                if (m_busy[d]) begin
                    m_done[d]++;
                    exp_hv[d] = mix(m_old[d], m_new[d], m_done[d], cw[d]);
                    if (m_done[d] == nch[d]) begin
                        m_busy[d]  = 1'b0;
                        exp_out[d] = 1'b1;
                    end
                end else if (en) begin
                    m_busy[d] = 1'b1;
                    m_done[d] = 0;
                    m_old[d]  = exp_hv[d];
                    m_new[d]  = hv1 ^ hv2;
                end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        checkOutput("out_a", D'(out_a), D'(exp_out[0]));
        checkOutput("hv_out_a", hv_out_a, exp_hv[0]);
        checkOutput("out_b", D'(out_b), D'(exp_out[1]));
        checkOutput("hv_out_b", hv_out_b, exp_hv[1]);
        if (exp_out[0]) checkOutput("top_chunk_a", hv_out_a >> 9000, exp_hv[0] >> 9000);
        if (exp_out[1]) checkOutput("top_chunk_b", hv_out_b >> 9000, exp_hv[1] >> 9000);
    endtask

    task automatic applyStimulus(input logic e, input logic [D-1:0] a, input logic [D-1:0] b);
        en  = e;
        hv1 = a;
        hv2 = b;
        tick();
    endtask

    initial begin
        logic [D-1:0] a;
        logic [D-1:0] b;

        $display("[TB] reset held, en pulses ignored");
        for (int i = 0; i < 6; i++) applyStimulus(1'(i % 2), rand_hv(), rand_hv());
        nrst = 1'b0;
        applyStimulus(1'b0, '0, '0);
        applyStimulus(1'b0, '0, '0);

        $display("[TB] small directed operands");
        a = '0; b = '0;
        a[4:0] = 5'b11101; b[4:0] = 5'b10010;
        applyStimulus(1'b1, a, b);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, a, b);
        a = '0; b = '0;
        a[4:0] = 5'b00101; b[4:0] = 5'b00111;
        applyStimulus(1'b1, a, b);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, rand_hv(), rand_hv());

        $display("[TB] full-width random operands, inputs changed after accept");
        applyStimulus(1'b1, rand_hv(), rand_hv());
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, rand_hv(), rand_hv());

        $display("[TB] en held high for 30 cycles");
        for (int i = 0; i < 30; i++) applyStimulus(1'b1, rand_hv(), rand_hv());
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, rand_hv(), rand_hv());

        $display("[TB] random request traffic");
        for (int i = 0; i < 50; i++) applyStimulus(1'($urandom_range(0, 3) == 0), rand_hv(), rand_hv());
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, rand_hv(), rand_hv());

        $display("[TB] reset in the middle of a request");
        applyStimulus(1'b1, rand_hv(), rand_hv());
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, rand_hv(), rand_hv());
        #2 nrst = 1'b1;
        #1;
        checkOutput("async_out_a", D'(out_a), '0);
        checkOutput("async_hv_a", hv_out_a, '0);
        checkOutput("async_out_b", D'(out_b), '0);
        checkOutput("async_hv_b", hv_out_b, '0);
        applyStimulus(1'b0, rand_hv(), rand_hv());
        applyStimulus(1'b0, rand_hv(), rand_hv());
        nrst = 1'b0;
        applyStimulus(1'b0, rand_hv(), rand_hv());
        applyStimulus(1'b1, rand_hv(), rand_hv());
        for (int i = 0; i < 13; i++) applyStimulus(1'b0, rand_hv(), rand_hv());

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
